spad_stream_ctrl: RTL



---
 rtl/spad_pkg.sv | 14 +
 rtl/spad_stream_ctrl_if.sv | 28 ++
 rtl/spad_stream_ctrl_rf.sv | 25 ++
 rtl/spad_stream_ctrl.sv | 82 ++++++++
 4 files changed

// File: rtl/spad_pkg.sv
// Helpers shared by the RF scratchpad streaming controllers.
package spad_pkg;

  // Width able to hold 0..size+1 (array entries plus the RF output register).
  function automatic int unsigned lvl_width(input int unsigned size);
    return $clog2(size + 2);
  endfunction

  // Circular pointer increment for a depth that need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned size);
    return (ptr == size - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/spad_stream_ctrl_if.sv
// Producer/consumer stream bundle for spad_stream_ctrl.
interface spad_stream_ctrl_if
  import spad_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SIZE  = 4
) ();
  localparam int unsigned LVL_WIDTH = lvl_width(SIZE);

  logic                 clr;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_ready;
  logic [LVL_WIDTH-1:0] level;

  modport master (
    output clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/spad_stream_ctrl_rf.sv
// RF scratchpad: one write port, one registered read port; dout holds when ren=0.
module spad_stream_ctrl_rf #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SIZE       = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  i_ren,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_din,
  output logic [WIDTH-1:0]      o_dout
);
  logic [WIDTH-1:0] r_mem [SIZE];
  logic [WIDTH-1:0] r_dout;

  // Storage is deliberately not reset; validity is tracked by the controller.
  always_ff @(posedge clk) begin
    if (i_wen) r_mem[i_waddr] <= i_din;
    if (i_ren) r_dout <= r_mem[i_raddr];
  end

  assign o_dout = r_dout;
endmodule

// File: rtl/spad_stream_ctrl.sv
// Drives one RF scratchpad as a circular FIFO, hiding its 1-cycle read latency.
module spad_stream_ctrl
  import spad_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned SIZE       = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(SIZE),
  parameter int unsigned LVL_WIDTH  = lvl_width(SIZE)
) (
  input logic              clk,
  input logic              rst,
  spad_stream_ctrl_if.slave bus
);
  localparam logic [LVL_WIDTH-1:0] CNT_FULL = LVL_WIDTH'(SIZE);

  logic [ADDR_WIDTH-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic [LVL_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic                  w_push, w_pop, w_rd_issue, w_wen, w_ren;

  assign bus.in_ready = (r_cnt != CNT_FULL);
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = r_out_valid && bus.out_ready;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign w_rd_issue   = (r_cnt != '0) && (!r_out_valid || bus.out_ready);
  assign w_wen        = w_push && !bus.clr;
  assign w_ren        = w_rd_issue && !bus.clr;

  always_comb begin
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid;
    if (bus.clr) begin
      w_wr_ptr_nxt    = '0;
      w_rd_ptr_nxt    = '0;
      w_cnt_nxt       = '0;
      w_out_valid_nxt = 1'b0;
    end else begin
      if (w_push) w_wr_ptr_nxt = ADDR_WIDTH'(ptr_inc(32'(r_wr_ptr), SIZE));
      if (w_rd_issue) w_rd_ptr_nxt = ADDR_WIDTH'(ptr_inc(32'(r_rd_ptr), SIZE));
      w_cnt_nxt = r_cnt + LVL_WIDTH'(w_push) - LVL_WIDTH'(w_rd_issue);
      if (w_rd_issue) begin
        w_out_valid_nxt = 1'b1;
      end else if (w_pop) begin
        w_out_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.level     = r_cnt + LVL_WIDTH'(r_out_valid);

  spad_stream_ctrl_rf #(
    .WIDTH      (WIDTH),
    .SIZE       (SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rf (
    .clk     (clk),
    .i_ren   (w_ren),
    .i_raddr (r_rd_ptr),
    .i_wen   (w_wen),
    .i_waddr (r_wr_ptr),
    .i_din   (bus.in_data),
    .o_dout  (bus.out_data)
  );
endmodule
